atm_txn_ctrl: RTL and testbench

Transaction controller that consumes the card record fetched by the card-handling block and produces its write-back. It captures the stored password and balance when `psw_en` rises, verifies the customer-entered PIN with limited retries, and executes balance inquiry, deposit and withdrawal against a local balance copy. It returns `updated_balance` together with an `op_done` or `card_out` strobe, which the card-handling block uses to update its balance memory.

---
 rtl/atm_txn_ctrl_if.sv | 37 +++
 rtl/atm_txn_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_txn_ctrl_if.sv
// Card-record and customer handshake bundle for the ATM transaction controller.
// The master drives the record and strobes, and the slave (the controller) returns the results.
interface atm_txn_ctrl_if #(
  parameter int password_width = 16,
  parameter int balance_width  = 20
);
  logic                      psw_en;
  logic [password_width-1:0] password;
  logic [balance_width-1:0]  balance;
  logic [password_width-1:0] entered_psw;
  logic                      psw_valid;
  logic [1:0]                op_code;
  logic [balance_width-1:0]  amount;
  logic                      op_valid;

  logic [balance_width-1:0]  updated_balance;
  logic [balance_width-1:0]  display_balance;
  logic                      op_done;
  logic                      card_out;
  logic                      wrong_psw;
  logic                      card_retained;
  logic                      insufficient;
  logic                      op_error;
  logic                      busy;

  modport master (
    output psw_en, password, balance, entered_psw, psw_valid, op_code, amount, op_valid,
    input  updated_balance, display_balance, op_done, card_out, wrong_psw,
           card_retained, insufficient, op_error, busy
  );

  modport slave (
    input  psw_en, password, balance, entered_psw, psw_valid, op_code, amount, op_valid,
    output updated_balance, display_balance, op_done, card_out, wrong_psw,
           card_retained, insufficient, op_error, busy
  );
endinterface

// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: verifies the PIN, runs inquiry/deposit/withdraw on a local
// balance copy and returns the write-back value with an op_done or card_out strobe.
module atm_txn_ctrl #(
  parameter int password_width = 16,
  parameter int balance_width  = 20,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 1000
) (
  input logic           clk,
  input logic           rst,
  atm_txn_ctrl_if.slave bus
);
  localparam int tries_w = $clog2(max_tries + 1);
  localparam int timer_w = $clog2(timeout_cycles);

  typedef enum logic [1:0] {IDLE, WAIT_PSW, MENU} state_t;
  typedef enum logic [1:0] {OP_INQUIRY, OP_DEPOSIT, OP_WITHDRAW, OP_EXIT} op_t;

  state_t state_q, state_d;

  logic [password_width-1:0] pw_q, pw_d;
  logic [balance_width-1:0]  bal_q, bal_d;
  logic [balance_width-1:0]  upd_q, upd_d;
  logic [balance_width-1:0]  disp_q, disp_d;
  logic [tries_w-1:0]        tries_q, tries_d;
  logic [timer_w-1:0]        timer_q, timer_d;
  logic op_done_q, op_done_d;
  logic card_out_q, card_out_d;
  logic wrong_q, wrong_d;
  logic retained_q, retained_d;
  logic insuff_q, insuff_d;
  logic op_error_q, op_error_d;
  logic busy_q, busy_d;

  // Event decode shared by the next-state and output processes.
  op_t                    op;
  logic                   psw_hit;
  logic                   op_hit;
  logic                   strobe;
  logic                   expire;
  logic                   pw_match;
  logic                   last_try;
  logic [balance_width:0] sum;
  logic                   short_funds;

  assign op          = op_t'(bus.op_code);
  assign psw_hit     = (state_q == WAIT_PSW) && bus.psw_valid;
  assign op_hit      = (state_q == MENU) && bus.op_valid;
  assign strobe      = psw_hit || op_hit;
  assign expire      = (state_q != IDLE) && !strobe &&
                       (timer_q == timer_w'(timeout_cycles - 1));
  assign pw_match    = (bus.entered_psw == pw_q);
  assign last_try    = (tries_q == tries_w'(max_tries - 1));
  assign sum         = {1'b0, bal_q} + {1'b0, bus.amount};
  assign short_funds = (bus.amount > bal_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.psw_en) state_d = WAIT_PSW;
      end
      WAIT_PSW: begin
        if (psw_hit) begin
          if (pw_match)      state_d = MENU;
          else if (last_try) state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      MENU: begin
        if (op_hit) begin
          if (op == OP_EXIT) state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets its default before the case so no path infers a latch.
    pw_d       = pw_q;
    bal_d      = bal_q;
    upd_d      = upd_q;
    disp_d     = disp_q;
    tries_d    = tries_q;
    op_done_d  = 1'b0;
    card_out_d = 1'b0;
    wrong_d    = 1'b0;
    retained_d = 1'b0;
    insuff_d   = 1'b0;
    op_error_d = 1'b0;
    busy_d     = (state_d != IDLE);

    // Idle timer: zero on state entry/exit and on every accepted strobe.
    if (state_q == IDLE || strobe || state_d != state_q) timer_d = '0;
    else                                                  timer_d = timer_q + timer_w'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.psw_en) begin
          pw_d    = bus.password;
          bal_d   = bus.balance;
          upd_d   = bus.balance;
          tries_d = '0;
        end
      end
      WAIT_PSW: begin
        if (psw_hit) begin
          if (!pw_match) begin
            tries_d = tries_q + tries_w'(1);
            if (last_try) retained_d = 1'b1;
            else          wrong_d    = 1'b1;
          end
        end else if (expire) begin
          card_out_d = 1'b1;
          upd_d      = bal_q;
        end
      end
      MENU: begin
        if (op_hit) begin
          unique case (op)
            OP_INQUIRY: begin
              disp_d    = bal_q;
              upd_d     = bal_q;
              op_done_d = 1'b1;
            end
            OP_DEPOSIT: begin
              if (sum[balance_width]) begin
                op_error_d = 1'b1;
              end else begin
                bal_d     = sum[balance_width-1:0];
                upd_d     = sum[balance_width-1:0];
                op_done_d = 1'b1;
              end
            end
            OP_WITHDRAW: begin
              if (short_funds) begin
                insuff_d = 1'b1;
              end else begin
                bal_d     = bal_q - bus.amount;
                upd_d     = bal_q - bus.amount;
                op_done_d = 1'b1;
              end
            end
            OP_EXIT: begin
              upd_d      = bal_q;
              card_out_d = 1'b1;
            end
            default: ;
          endcase
        end else if (expire) begin
          card_out_d = 1'b1;
          upd_d      = bal_q;
        end
      end
      default: ;
    endcase
  end

  // The stored record is cleared on reset too, so a dropped session leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pw_q       <= '0;
      bal_q      <= '0;
      upd_q      <= '0;
      disp_q     <= '0;
      tries_q    <= '0;
      timer_q    <= '0;
      op_done_q  <= 1'b0;
      card_out_q <= 1'b0;
      wrong_q    <= 1'b0;
      retained_q <= 1'b0;
      insuff_q   <= 1'b0;
      op_error_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pw_q       <= pw_d;
      bal_q      <= bal_d;
      upd_q      <= upd_d;
      disp_q     <= disp_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      op_done_q  <= op_done_d;
      card_out_q <= card_out_d;
      wrong_q    <= wrong_d;
      retained_q <= retained_d;
      insuff_q   <= insuff_d;
      op_error_q <= op_error_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.updated_balance = upd_q;
  assign bus.display_balance = disp_q;
  assign bus.op_done         = op_done_q;
  assign bus.card_out        = card_out_q;
  assign bus.wrong_psw       = wrong_q;
  assign bus.card_retained   = retained_q;
  assign bus.insufficient    = insuff_q;
  assign bus.op_error        = op_error_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Self-checking bench for atm_txn_ctrl: directed scenarios plus a randomized run
// compared every cycle against a session-level reference model.
module tb_atm_txn_ctrl;
  localparam int PW    = 16;
  localparam int BW    = 20;
  localparam int TRIES = 3;
  localparam int TO    = 8;
  localparam int unsigned BAL_MAX = (32'd1 << BW) - 1;
  localparam int VW    = 2 * BW + 7;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  atm_txn_ctrl_if #(.password_width(PW), .balance_width(BW)) bus();

  atm_txn_ctrl #(
    .password_width(PW),
    .balance_width (BW),
    .max_tries     (TRIES),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: session phase 0 = no card, 1 = awaiting PIN, 2 = menu.
  int            m_phase;
  logic [PW-1:0] m_pw;
  longint        m_bal;
  int            m_tries;
  int            m_idle;
  longint        e_upd, e_disp;
  bit            e_done, e_out, e_wrong, e_ret, e_ins, e_err;

  task automatic model_reset();
    m_phase = 0; m_pw = '0; m_bal = 0; m_tries = 0; m_idle = 0;
    e_upd = 0; e_disp = 0;
    {e_done, e_out, e_wrong, e_ret, e_ins, e_err} = '0;
  endtask

  task automatic idle_tick();
    if (m_idle == TO - 1) begin
      e_out = 1; e_upd = m_bal; m_phase = 0; m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  task automatic model_step();
    {e_done, e_out, e_wrong, e_ret, e_ins, e_err} = '0;
    if (m_phase == 0) begin
      if (bus.psw_en) begin
        m_pw = bus.password; m_bal = bus.balance; e_upd = m_bal;
        m_tries = 0; m_idle = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.psw_valid) begin
        m_idle = 0;
        if (bus.entered_psw == m_pw) m_phase = 2;
        else begin
          m_tries++;
          if (m_tries >= TRIES) begin e_ret = 1; m_phase = 0; end
          else e_wrong = 1;
        end
      end else idle_tick();
    end else begin
      if (bus.op_valid) begin
        m_idle = 0;
        case (bus.op_code)
          2'b00: begin e_disp = m_bal; e_upd = m_bal; e_done = 1; end
          2'b01: if (m_bal + longint'(bus.amount) > longint'(BAL_MAX)) e_err = 1;
                 else begin m_bal = m_bal + longint'(bus.amount); e_upd = m_bal; e_done = 1; end
          2'b10: if (longint'(bus.amount) > m_bal) e_ins = 1;
                 else begin m_bal = m_bal - longint'(bus.amount); e_upd = m_bal; e_done = 1; end
          default: begin e_upd = m_bal; e_out = 1; m_phase = 0; end
        endcase
      end else idle_tick();
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [BW-1:0] u, d;
    u = BW'(e_upd);
    d = BW'(e_disp);
    return {u, d, e_done, e_out, e_wrong, e_ret, e_ins, e_err, (m_phase != 0)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.updated_balance, bus.display_balance, bus.op_done, bus.card_out, bus.wrong_psw,
            bus.card_retained, bus.insufficient, bus.op_error, bus.busy};
  endfunction

  // One clock: the model consumes the driven inputs, then outputs are sampled 1 ns after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    bus.psw_en = 1'b0; bus.psw_valid = 1'b0; bus.op_valid = 1'b0;
  endtask

  task automatic start_session(input logic [PW-1:0] pw, input logic [BW-1:0] bal);
    bus.psw_en = 1'b1; bus.password = pw; bus.balance = bal;
    step();
  endtask

  task automatic enter_pin(input logic [PW-1:0] pin);
    bus.psw_valid = 1'b1; bus.entered_psw = pin;
    step();
  endtask

  task automatic do_op(input logic [1:0] code, input logic [BW-1:0] amt);
    bus.op_valid = 1'b1; bus.op_code = code; bus.amount = amt;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_hold: outputs=%h want 0", dut_vec());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_release: outputs=%h want 0", dut_vec());
    end
  endtask

  task automatic test_login_inquiry();
    start_session(16'h1234, 20'd500);
    checks++;
    if (bus.busy !== 1'b1 || bus.updated_balance !== 20'd500) begin
      errors++; $display("FAIL session_start: busy=%b upd=%0d want 1 and 500", bus.busy, bus.updated_balance);
    end
    enter_pin(16'h1234);
    checks++;
    if (bus.wrong_psw !== 1'b0 || bus.card_retained !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL pin_ok: wrong=%b retained=%b busy=%b want 0 0 1",
                         bus.wrong_psw, bus.card_retained, bus.busy);
    end
    do_op(2'b00, '0);
    checks++;
    if (bus.op_done !== 1'b1 || bus.display_balance !== 20'd500 || bus.updated_balance !== 20'd500) begin
      errors++; $display("FAIL inquiry: done=%b disp=%0d upd=%0d want 1 500 500",
                         bus.op_done, bus.display_balance, bus.updated_balance);
    end
    step();
    checks++;
    if (bus.op_done !== 1'b0) begin
      errors++; $display("FAIL inquiry_pulse: done=%b want 0", bus.op_done);
    end
    do_op(2'b11, '0);
    checks++;
    if (bus.card_out !== 1'b1 || bus.busy !== 1'b0 || bus.updated_balance !== 20'd500) begin
      errors++; $display("FAIL exit: out=%b busy=%b upd=%0d want 1 0 500",
                         bus.card_out, bus.busy, bus.updated_balance);
    end
  endtask

  task automatic test_wrong_pin();
    start_session(16'h1234, 20'd500);
    for (int i = 0; i < TRIES; i++) begin
      enter_pin(16'h1111);
      checks++;
      if (bus.wrong_psw !== (i < TRIES - 1) || bus.card_retained !== (i == TRIES - 1) ||
          bus.card_out !== 1'b0 || bus.op_done !== 1'b0) begin
        errors++; $display("FAIL wrong_pin_%0d: wrong=%b retained=%b out=%b done=%b", i,
                           bus.wrong_psw, bus.card_retained, bus.card_out, bus.op_done);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL retained_idle: busy=%b want 0", bus.busy);
    end
    // Nothing may follow a retained card: no eject, no commit, PIN strobes ignored.
    for (int i = 0; i < TO + 2; i++) begin
      if (i == 2) begin bus.psw_valid = 1'b1; bus.entered_psw = 16'h1234; end
      step();
      checks++;
      if (bus.card_out !== 1'b0 || bus.op_done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL retained_quiet_%0d: out=%b done=%b busy=%b",
                           i, bus.card_out, bus.op_done, bus.busy);
      end
    end
  endtask

  task automatic test_withdraw();
    start_session(16'h1234, 20'd500);
    enter_pin(16'h1234);
    do_op(2'b10, 20'd600);
    checks++;
    if (bus.insufficient !== 1'b1 || bus.op_done !== 1'b0) begin
      errors++; $display("FAIL withdraw_600: insuff=%b done=%b want 1 0", bus.insufficient, bus.op_done);
    end
    do_op(2'b10, 20'd500);
    checks++;
    if (bus.op_done !== 1'b1 || bus.insufficient !== 1'b0 || bus.updated_balance !== 20'd0) begin
      errors++; $display("FAIL withdraw_500: done=%b insuff=%b upd=%0d want 1 0 0",
                         bus.op_done, bus.insufficient, bus.updated_balance);
    end
    do_op(2'b10, 20'd0);
    checks++;
    if (bus.op_done !== 1'b1 || bus.insufficient !== 1'b0 || bus.updated_balance !== 20'd0) begin
      errors++; $display("FAIL withdraw_0: done=%b insuff=%b upd=%0d want 1 0 0",
                         bus.op_done, bus.insufficient, bus.updated_balance);
    end
    do_op(2'b11, '0);
  endtask

  task automatic test_deposit_overflow();
    start_session(16'h00AA, 20'hFFFF0);
    enter_pin(16'h00AA);
    do_op(2'b01, 20'h10);
    checks++;
    if (bus.op_error !== 1'b1 || bus.op_done !== 1'b0 || bus.updated_balance !== 20'hFFFF0) begin
      errors++; $display("FAIL deposit_overflow: err=%b done=%b upd=%h want 1 0 FFFF0",
                         bus.op_error, bus.op_done, bus.updated_balance);
    end
    do_op(2'b01, 20'd15);
    checks++;
    if (bus.op_done !== 1'b1 || bus.op_error !== 1'b0 || bus.updated_balance !== 20'hFFFFF) begin
      errors++; $display("FAIL deposit_to_max: done=%b err=%b upd=%h want 1 0 FFFFF",
                         bus.op_done, bus.op_error, bus.updated_balance);
    end
    do_op(2'b11, '0);
    checks++;
    if (bus.card_out !== 1'b1 || bus.updated_balance !== 20'hFFFFF) begin
      errors++; $display("FAIL deposit_exit: out=%b upd=%h want 1 FFFFF", bus.card_out, bus.updated_balance);
    end
  endtask

  // Counts cycles from the call until card_out, bounded so a missing eject cannot hang.
  task automatic wait_eject(input string name, input int want);
    int n;
    n = 0;
    while (n < 3 * TO) begin
      step();
      n++;
      if (bus.card_out === 1'b1) break;
    end
    checks++;
    if (bus.card_out !== 1'b1 || n != want || bus.updated_balance !== 20'd500 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s: eject after %0d cycles (out=%b upd=%0d busy=%b) want %0d cycles upd 500",
                         name, n, bus.card_out, bus.updated_balance, bus.busy, want);
    end
  endtask

  task automatic test_timeout();
    start_session(16'h4321, 20'd500);
    enter_pin(16'h4321);
    wait_eject("timeout_menu", TO);

    start_session(16'h4321, 20'd500);
    enter_pin(16'h4321);
    for (int i = 0; i < TO - 1; i++) step();
    do_op(2'b00, '0);
    checks++;
    if (bus.op_done !== 1'b1 || bus.card_out !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL timeout_strobe_wins: done=%b out=%b busy=%b want 1 0 1",
                         bus.op_done, bus.card_out, bus.busy);
    end
    wait_eject("timeout_restart", TO);

    start_session(16'h4321, 20'd500);
    wait_eject("timeout_wait_psw", TO);
  endtask

  task automatic test_deposit_exit();
    start_session(16'h2222, 20'd500);
    enter_pin(16'h2222);
    do_op(2'b01, 20'd100);
    checks++;
    if (bus.op_done !== 1'b1 || bus.updated_balance !== 20'd600) begin
      errors++; $display("FAIL deposit_100: done=%b upd=%0d want 1 600", bus.op_done, bus.updated_balance);
    end
    do_op(2'b11, '0);
    checks++;
    if (bus.card_out !== 1'b1 || bus.updated_balance !== 20'd600 || bus.op_done !== 1'b0) begin
      errors++; $display("FAIL exit_600: out=%b upd=%0d done=%b want 1 600 0",
                         bus.card_out, bus.updated_balance, bus.op_done);
    end
  endtask

  task automatic test_reset_mid_menu();
    start_session(16'h3333, 20'd700);
    enter_pin(16'h3333);
    do_op(2'b00, '0);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_mid_menu: outputs=%h want 0", dut_vec());
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.psw_valid = 1'b1; bus.entered_psw = 16'h3333;
      bus.op_valid = 1'b1; bus.op_code = 2'b11;
      step();
      checks++;
      if (dut_vec() !== '0) begin
        errors++; $display("FAIL reset_after_%0d: outputs=%h want 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_random();
    int unsigned r;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      bus.psw_en   = (r < 12);
      bus.password = PW'($urandom_range(0, 3));
      bus.balance  = ($urandom_range(0, 1) == 0) ? BW'($urandom_range(0, 2000))
                                                 : BW'(BAL_MAX - $urandom_range(0, 300));
      bus.psw_valid   = ($urandom_range(0, 99) < 35);
      bus.entered_psw = ($urandom_range(0, 2) != 0) ? m_pw : PW'($urandom_range(0, 3));
      bus.op_valid = ($urandom_range(0, 99) < 35);
      bus.op_code  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.amount   = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, BAL_MAX))
                                                 : BW'($urandom_range(0, 800));
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.psw_en = 1'b0; bus.password = '0; bus.balance = '0;
    bus.entered_psw = '0; bus.psw_valid = 1'b0;
    bus.op_code = '0; bus.amount = '0; bus.op_valid = 1'b0;
    model_reset();

    test_reset();
    test_login_inquiry();
    test_wrong_pin();
    test_withdraw();
    test_deposit_overflow();
    test_timeout();
    test_deposit_exit();
    test_reset_mid_menu();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
